// File: rtl/mu0_control.sv
// -----------------------------------------------------------------------------
// mu0_control
// Control unit for the MU0 datapath. It runs the fetch/execute sequence for
// the 8-instruction MU0 ISA. It drives the register enables, the mux selects,
// the ALU function and the memory strobes. Every memory access waits for
// MemAck. An access that waits longer than TIMEOUT cycles halts the CPU and
// sets the sticky Err flag.
//
// Ports
//   Clk     in   system clock, rising edge
//   Reset   in   asynchronous, active-high reset
//   F       in   [3:0] opcode, IR[15:12]
//   N       in   ACC negative flag (ACC[15])
//   Z       in   ACC zero flag
//   MemAck  in   memory completes the current Rd/Wr this cycle
//   PCEn    out  PC load enable
//   IREn    out  IR load enable
//   AccEn   out  ACC load enable
//   XSel    out  address mux: 0 = PC, 1 = IR[11:0]
//   YSel    out  ALU Y operand: 0 = memory data, 1 = PC
//   PCSel   out  PC input: 0 = ALU result, 1 = IR[11:0]
//   ALUFn   out  [1:0] 00 = pass Y, 01 = X+Y, 10 = X-Y, 11 = Y+1
//   Rd      out  memory read strobe
//   Wr      out  memory write strobe
//   Fetch   out  high in FETCH state
//   Halted  out  high in HALT state
//   Err     out  sticky bus-timeout flag
//
// Parameters
//   TIMEOUT  maximum consecutive wait cycles before a bus error (1..255)
//   CNT_W    wait counter width; 2**CNT_W must exceed TIMEOUT
// -----------------------------------------------------------------------------
module mu0_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       MemAck,
    output logic       PCEn,
    output logic       IREn,
    output logic       AccEn,
    output logic       XSel,
    output logic       YSel,
    output logic       PCSel,
    output logic [1:0] ALUFn,
    output logic       Rd,
    output logic       Wr,
    output logic       Fetch,
    output logic       Halted,
    output logic       Err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             mem_access;   // a memory strobe is held this cycle
    logic             timeout;

    // State, wait counter and sticky error flag.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= err_q | timeout;
            if (next_state != state)
                wait_cnt <= '0;
            else if (mem_access && !MemAck)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next state and outputs.
    // NOTE: every output gets a default before the case statement. This
    // prevents inferred latches and makes unlisted outputs 0.
    always_comb begin
        next_state = state;
        mem_access = 1'b0;
        timeout    = 1'b0;
        PCEn       = 1'b0;
        IREn       = 1'b0;
        AccEn      = 1'b0;
        XSel       = 1'b0;
        YSel       = 1'b0;
        PCSel      = 1'b0;
        ALUFn      = 2'b00;
        Rd         = 1'b0;
        Wr         = 1'b0;
        Halted     = 1'b0;

        unique case (state)
            FETCH: begin
                Rd         = 1'b1;
                YSel       = 1'b1;
                ALUFn      = 2'b11;     // PC + 1 while IR loads
                mem_access = 1'b1;
                if (MemAck) begin
                    IREn       = 1'b1;
                    PCEn       = 1'b1;
                    next_state = EXEC;
                end
            end

            EXEC: begin
                case (F)
                    4'd0, 4'd2, 4'd3: begin     // LDA / ADD / SUB
                        Rd         = 1'b1;
                        XSel       = 1'b1;
                        mem_access = 1'b1;
                        ALUFn      = (F == 4'd2) ? 2'b01 :
                                     (F == 4'd3) ? 2'b10 : 2'b00;
                        if (MemAck) begin
                            AccEn      = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    4'd1: begin                  // STA
                        Wr         = 1'b1;
                        XSel       = 1'b1;
                        mem_access = 1'b1;
                        if (MemAck)
                            next_state = FETCH;
                    end
                    4'd4: begin                  // JMP
                        PCSel      = 1'b1;
                        PCEn       = 1'b1;
                        next_state = FETCH;
                    end
                    4'd5: begin                  // JGE
                        PCSel      = 1'b1;
                        PCEn       = ~N;
                        next_state = FETCH;
                    end
                    4'd6: begin                  // JNE
                        PCSel      = 1'b1;
                        PCEn       = ~Z;
                        next_state = FETCH;
                    end
                    4'd7:    next_state = HALT;  // STP
                    default: next_state = FETCH; // undefined opcodes act as NOP
                endcase
            end

            HALT: Halted = 1'b1;

            default: next_state = FETCH;
        endcase

        // The access has waited too long and MemAck has not arrived.
        // The enables are already 0 because they are gated by MemAck. A
        // MemAck in the same cycle completes the access normally instead.
        if (mem_access && !MemAck && (wait_cnt == CNT_W'(TIMEOUT))) begin
            timeout    = 1'b1;
            next_state = HALT;
        end

        // While Reset is held, the strobes and enables stay 0 even though
        // the state register already shows FETCH.
        if (Reset) begin
            PCEn  = 1'b0;
            IREn  = 1'b0;
            AccEn = 1'b0;
            Rd    = 1'b0;
            Wr    = 1'b0;
        end
    end

    assign Fetch = (state == FETCH);
    assign Err   = err_q;

endmodule

// File: tb/tb_mu0_control.sv
// -----------------------------------------------------------------------------
// tb_mu0_control
// Directed, self-checking bench for mu0_control with TIMEOUT = 15.
// Inputs change 1 time unit after a rising edge. Outputs are compared
// 1 time unit later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_mu0_control;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] F;
    logic       N, Z, MemAck;
    logic       PCEn, IREn, AccEn, XSel, YSel, PCSel;
    logic [1:0] ALUFn;
    logic       Rd, Wr, Fetch, Halted, Err;

    int n_checks = 0;
    int n_fail   = 0;

    mu0_control #(.TIMEOUT(15), .CNT_W(8)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .F      (F),
        .N      (N),
        .Z      (Z),
        .MemAck (MemAck),
        .PCEn   (PCEn),
        .IREn   (IREn),
        .AccEn  (AccEn),
        .XSel   (XSel),
        .YSel   (YSel),
        .PCSel  (PCSel),
        .ALUFn  (ALUFn),
        .Rd     (Rd),
        .Wr     (Wr),
        .Fetch  (Fetch),
        .Halted (Halted),
        .Err    (Err)
    );

    always #5 Clk = ~Clk;

    // Compare all outputs at once.
    // Field order: PCEn IREn AccEn XSel YSel PCSel ALUFn[1:0] Rd Wr Fetch Halted Err
    task automatic expect_out(input string tag,
                              input logic pcen, input logic iren, input logic accen,
                              input logic xsel, input logic ysel, input logic pcsel,
                              input logic [1:0] alufn, input logic rd, input logic wr,
                              input logic fetch, input logic halted, input logic err);
        logic [12:0] obs, exp;
        obs = {PCEn, IREn, AccEn, XSel, YSel, PCSel, ALUFn, Rd, Wr, Fetch, Halted, Err};
        exp = {pcen, iren, accen, xsel, ysel, pcsel, alufn, rd, wr, fetch, halted, err};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0; MemAck = 1'b1;

        // ---- Reset state: FETCH with strobes gated off ----
        #2;
        expect_out("reset", 0,0,0, 0,1,0, 2'b11, 0,0, 1,0,0);
        cycle();
        Reset = 1'b0;
        #1;

        // ---- LDA, zero-wait ----
        expect_out("lda_fetch", 1,1,0, 0,1,0, 2'b11, 1,0, 1,0,0);
        cycle(); #1;
        expect_out("lda_exec",  0,0,1, 1,0,0, 2'b00, 1,0, 0,0,0);
        cycle(); #1;
        expect_out("lda_back",  1,1,0, 0,1,0, 2'b11, 1,0, 1,0,0);

        // ---- JGE N=1 (not taken), JGE N=0 (taken), JNE Z=1 ----
        F = 4'd5; N = 1'b1;
        cycle(); #1;
        expect_out("jge_n1", 0,0,0, 0,0,1, 2'b00, 0,0, 0,0,0);
        cycle(); N = 1'b0; #1;
        expect_out("jge_fetch", 1,1,0, 0,1,0, 2'b11, 1,0, 1,0,0);
        cycle(); #1;
        expect_out("jge_n0", 1,0,0, 0,0,1, 2'b00, 0,0, 0,0,0);
        cycle(); F = 4'd6; Z = 1'b1;
        cycle(); #1;
        expect_out("jne_z1", 0,0,0, 0,0,1, 2'b00, 0,0, 0,0,0);
        cycle(); Z = 1'b0; F = 4'd4;
        cycle(); #1;
        expect_out("jmp", 1,0,0, 0,0,1, 2'b00, 0,0, 0,0,0);

        // ---- STA with three wait cycles ----
        cycle(); F = 4'd1;
        cycle(); MemAck = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("sta_wait%0d", i), 0,0,0, 1,0,0, 2'b00, 0,1, 0,0,0);
            cycle(); #1;
        end
        MemAck = 1'b1; #1;
        expect_out("sta_ack", 0,0,0, 1,0,0, 2'b00, 0,1, 0,0,0);
        cycle(); #1;
        expect_out("sta_done", 1,1,0, 0,1,0, 2'b11, 1,0, 1,0,0);

        // ---- Boundary: MemAck arrives on the last allowed wait cycle ----
        F = 4'd9; MemAck = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        MemAck = 1'b1; #1;
        expect_out("ack_at_limit", 1,1,0, 0,1,0, 2'b11, 1,0, 1,0,0);

        // ---- Undefined opcode acts as a NOP ----
        cycle(); #1;
        expect_out("nop_exec", 0,0,0, 0,0,0, 2'b00, 0,0, 0,0,0);
        cycle(); #1;
        expect_out("nop_back", 1,1,0, 0,1,0, 2'b11, 1,0, 1,0,0);

        // ---- Timeout in FETCH: Rd for 16 cycles, then HALT + Err ----
        MemAck = 1'b0; #1;
        for (int i = 0; i < 16; i++) begin
            expect_out($sformatf("to_rd%0d", i), 0,0,0, 0,1,0, 2'b11, 1,0, 1,0,0);
            cycle(); #1;
        end
        expect_out("to_halt", 0,0,0, 0,0,0, 2'b00, 0,0, 0,1,1);
        MemAck = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(); #1;
            expect_out($sformatf("halt_hold%0d", i), 0,0,0, 0,0,0, 2'b00, 0,0, 0,1,1);
        end

        // ---- Reset pulse between edges clears HALT and Err at once ----
        Reset = 1'b1; #1;
        expect_out("halt_reset", 0,0,0, 0,1,0, 2'b11, 0,0, 1,0,0);
        #1 Reset = 1'b0;

        // ---- STP ----
        F = 4'd7;
        cycle(); #1;
        expect_out("stp_exec", 0,0,0, 0,0,0, 2'b00, 0,0, 0,0,0);
        cycle(); #1;
        expect_out("stp_halt", 0,0,0, 0,0,0, 2'b00, 0,0, 0,1,0);
        Reset = 1'b1; #1;
        expect_out("stp_reset", 0,0,0, 0,1,0, 2'b11, 0,0, 1,0,0);
        #1 Reset = 1'b0;

        // ---- ADD with a wait, interrupted by Reset ----
        F = 4'd2;
        cycle(); MemAck = 1'b0; #1;
        expect_out("add_wait", 0,0,0, 1,0,0, 2'b01, 1,0, 0,0,0);
        MemAck = 1'b1; #1;
        expect_out("add_ack", 0,0,1, 1,0,0, 2'b01, 1,0, 0,0,0);
        Reset = 1'b1; #1;
        expect_out("add_reset", 0,0,0, 0,1,0, 2'b11, 0,0, 1,0,0);
        cycle();
        Reset = 1'b0; #1;
        expect_out("add_resume", 1,1,0, 0,1,0, 2'b11, 1,0, 1,0,0);

        // ---- SUB, zero-wait ----
        F = 4'd3;
        cycle(); #1;
        expect_out("sub_exec", 0,0,1, 1,0,0, 2'b10, 1,0, 0,0,0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
